// File: rtl/wb_master_arbiter_pkg.sv
// rtl/wb_master_arbiter_pkg.sv - shared types and constants for the Wishbone master arbiter
//
// Purpose: arbiter state encoding, grant encodings and Wishbone width constants,
//          shared by the arbiter top and its watchdog sub-module.
// Ports:   none (package).
package wb_master_arbiter_pkg;

  localparam int WB_ADR_W  = 28;
  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = 4;
  localparam int WD_CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2,
    ST_ABORT  = 2'd3
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  // One-hot owner derived purely from the (registered) state.
  function automatic logic [1:0] grant_of_state(input arb_state_t s);
    case (s)
      ST_GRANT0: grant_of_state = GRANT_M0;
      ST_GRANT1: grant_of_state = GRANT_M1;
      default:   grant_of_state = GRANT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// rtl/wb_timeout_counter.sv - saturating watchdog counter with programmable limit
//
// Purpose: counts cycles while enable is high, clears on clear, and flags
//          expired in the cycle the count reaches limit-1 while still enabled.
// Ports:
//   wb_clk_i  in   clock
//   wb_rst_n  in   synchronous active-low reset
//   enable    in   count this cycle
//   clear     in   return the count to zero (wins over enable)
//   limit     in   number of enabled cycles until expiry (1..255)
//   expired   out  combinational: enabled and count == limit-1
module wb_timeout_counter
  import wb_master_arbiter_pkg::*;
(
  input  logic                wb_clk_i,
  input  logic                wb_rst_n,
  input  logic                enable,
  input  logic                clear,
  input  logic [WD_CNT_W-1:0] limit,
  output logic                expired
);

  localparam logic [WD_CNT_W-1:0] ONE = {{(WD_CNT_W-1){1'b0}}, 1'b1};

  logic [WD_CNT_W-1:0] count_q;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != '1)) begin
      // Saturates at all-ones instead of wrapping back to zero.
      count_q <= count_q + ONE;
    end
  end

  assign expired = enable && (count_q == (limit - ONE));

endmodule

// File: rtl/wb_master_arbiter.sv
// rtl/wb_master_arbiter.sv - two-master Wishbone arbiter onto one shared port with watchdog
//
// Purpose: grants the shared Caravel master port to one of two Wishbone
//          requesters, alternating on ties, and aborts an access that waits
//          TIMEOUT_CYCLES cycles without ack or error.
// Ports:
//   wb_clk_i, wb_rst_n             clock, synchronous active-low reset
//   mk_wb_{cyc,stb,we,sel,data,adr}_i  request from master k (k = 0, 1)
//   mk_wb_{ack,stall,error,data}_o     response to master k
//   s_wb_{cyc,stb,we,sel,data,adr}_o   shared port request
//   s_wb_{ack,stall,error,data}_i      shared port response
//   grant_o                        one-hot current owner, 00 when none
//   timeout_o                      one-cycle pulse on each abort
module wb_master_arbiter
  import wb_master_arbiter_pkg::*;
#(
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_n,

  input  logic                 m0_wb_cyc_i,
  input  logic                 m0_wb_stb_i,
  input  logic                 m0_wb_we_i,
  input  logic [WB_SEL_W-1:0]  m0_wb_sel_i,
  input  logic [WB_DATA_W-1:0] m0_wb_data_i,
  input  logic [WB_ADR_W-1:0]  m0_wb_adr_i,
  output logic                 m0_wb_ack_o,
  output logic                 m0_wb_stall_o,
  output logic                 m0_wb_error_o,
  output logic [WB_DATA_W-1:0] m0_wb_data_o,

  input  logic                 m1_wb_cyc_i,
  input  logic                 m1_wb_stb_i,
  input  logic                 m1_wb_we_i,
  input  logic [WB_SEL_W-1:0]  m1_wb_sel_i,
  input  logic [WB_DATA_W-1:0] m1_wb_data_i,
  input  logic [WB_ADR_W-1:0]  m1_wb_adr_i,
  output logic                 m1_wb_ack_o,
  output logic                 m1_wb_stall_o,
  output logic                 m1_wb_error_o,
  output logic [WB_DATA_W-1:0] m1_wb_data_o,

  output logic                 s_wb_cyc_o,
  output logic                 s_wb_stb_o,
  output logic                 s_wb_we_o,
  output logic [WB_SEL_W-1:0]  s_wb_sel_o,
  output logic [WB_DATA_W-1:0] s_wb_data_o,
  output logic [WB_ADR_W-1:0]  s_wb_adr_o,
  input  logic                 s_wb_ack_i,
  input  logic                 s_wb_stall_i,
  input  logic                 s_wb_error_i,
  input  logic [WB_DATA_W-1:0] s_wb_data_i,

  output logic [1:0]           grant_o,
  output logic                 timeout_o
);

  arb_state_t state_q;
  arb_state_t state_next;
  arb_state_t cur_state;
  logic       last_owner_q;   // index of the master granted most recently

  logic in_grant;
  logic owner_cyc;
  logic wd_enable;
  logic wd_clear;
  logic wd_expired;

  // While reset is held the combinational outputs must already look like
  // IDLE, so a mid-transfer reset drops s_wb_cyc_o in the same cycle.
  assign cur_state = wb_rst_n ? state_q : ST_IDLE;

  assign in_grant  = (cur_state == ST_GRANT0) || (cur_state == ST_GRANT1);
  assign owner_cyc = (cur_state == ST_GRANT1) ? m1_wb_cyc_i : m0_wb_cyc_i;

  // Count only genuine waiting cycles of the owner; any response resets it.
  assign wd_enable = in_grant && owner_cyc && !s_wb_ack_i && !s_wb_error_i;
  assign wd_clear  = !in_grant || s_wb_ack_i || s_wb_error_i;

  wb_timeout_counter u_watchdog (
    .wb_clk_i (wb_clk_i),
    .wb_rst_n (wb_rst_n),
    .enable   (wd_enable),
    .clear    (wd_clear),
    .limit    (TIMEOUT_CYCLES),
    .expired  (wd_expired)
  );

  // State register and tie-break history.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      state_q      <= ST_IDLE;
      last_owner_q <= 1'b1;
    end else begin
      state_q <= state_next;
      if (state_q == ST_IDLE && state_next == ST_GRANT0) begin
        last_owner_q <= 1'b0;
      end else if (state_q == ST_IDLE && state_next == ST_GRANT1) begin
        last_owner_q <= 1'b1;
      end
    end
  end

  // Next-state logic. Owners always pass through IDLE before a new grant.
  always_comb begin
    state_next = state_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_wb_cyc_i && m1_wb_cyc_i) begin
          state_next = last_owner_q ? ST_GRANT0 : ST_GRANT1;
        end else if (m0_wb_cyc_i) begin
          state_next = ST_GRANT0;
        end else if (m1_wb_cyc_i) begin
          state_next = ST_GRANT1;
        end
      end
      ST_GRANT0: begin
        if (!m0_wb_cyc_i) begin
          state_next = ST_IDLE;
        end else if (wd_expired) begin
          state_next = ST_ABORT;
        end
      end
      ST_GRANT1: begin
        if (!m1_wb_cyc_i) begin
          state_next = ST_IDLE;
        end else if (wd_expired) begin
          state_next = ST_ABORT;
        end
      end
      ST_ABORT: begin
        // last_owner_q still names the master that was aborted.
        if (!(last_owner_q ? m1_wb_cyc_i : m0_wb_cyc_i)) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output muxing keyed on the registered state only.
  always_comb begin
    s_wb_cyc_o    = 1'b0;
    s_wb_stb_o    = 1'b0;
    s_wb_we_o     = 1'b0;
    s_wb_sel_o    = '0;
    s_wb_data_o   = '0;
    s_wb_adr_o    = '0;
    m0_wb_ack_o   = 1'b0;
    m0_wb_stall_o = 1'b1;
    m0_wb_error_o = 1'b0;
    m0_wb_data_o  = '0;
    m1_wb_ack_o   = 1'b0;
    m1_wb_stall_o = 1'b1;
    m1_wb_error_o = 1'b0;
    m1_wb_data_o  = '0;
    timeout_o     = 1'b0;
    grant_o       = grant_of_state(cur_state);
    case (cur_state)
      ST_GRANT0: begin
        s_wb_cyc_o    = m0_wb_cyc_i;
        s_wb_stb_o    = m0_wb_stb_i;
        s_wb_we_o     = m0_wb_we_i;
        s_wb_sel_o    = m0_wb_sel_i;
        s_wb_data_o   = m0_wb_data_i;
        s_wb_adr_o    = m0_wb_adr_i;
        // A response arriving after the owner dropped cyc is swallowed.
        m0_wb_ack_o   = s_wb_ack_i && m0_wb_cyc_i;
        m0_wb_error_o = (s_wb_error_i && m0_wb_cyc_i) || wd_expired;
        m0_wb_stall_o = s_wb_stall_i;
        m0_wb_data_o  = s_wb_data_i;
        timeout_o     = wd_expired;
      end
      ST_GRANT1: begin
        s_wb_cyc_o    = m1_wb_cyc_i;
        s_wb_stb_o    = m1_wb_stb_i;
        s_wb_we_o     = m1_wb_we_i;
        s_wb_sel_o    = m1_wb_sel_i;
        s_wb_data_o   = m1_wb_data_i;
        s_wb_adr_o    = m1_wb_adr_i;
        m1_wb_ack_o   = s_wb_ack_i && m1_wb_cyc_i;
        m1_wb_error_o = (s_wb_error_i && m1_wb_cyc_i) || wd_expired;
        m1_wb_stall_o = s_wb_stall_i;
        m1_wb_data_o  = s_wb_data_i;
        timeout_o     = wd_expired;
      end
      default: begin
      end
    endcase
  end

endmodule
